// File: rtl/symbol_stream_feeder.sv
// symbol_stream_feeder
//   Loads packed sequence words into an internal buffer, then replays them as SYM_W-bit symbols,
//   LSB-first, over a valid/ready handshake. Symbols are paced at one per HOLD cycles.
//   Replay is either one-shot or looping.
//
// Ports
//   CLK, RST             clock, synchronous active-high reset
//   load_valid/ready     packed-word load handshake, load_data holds the word (symbol 0 in LSBs)
//   clear                discard loaded words, clear done/err (ignored while streaming)
//   start/start_len      begin replay of start_len symbols; loop_en sampled alongside
//   stop                 end replay at the next symbol boundary
//   sym_valid/ready      symbol handshake; sym_data is the symbol, sym_last marks index len-1
//   sym_count            symbols accepted since start (saturating)
//   busy/done/err        streaming, replay finished, sticky error
module symbol_stream_feeder #(
  parameter int unsigned SYM_W  = 2,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned HOLD   = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready,
  input  logic              clear,
  input  logic              start,
  input  logic [CNT_W-1:0]  start_len,
  input  logic              loop_en,
  input  logic              stop,
  output logic              sym_valid,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_last,
  input  logic              sym_ready,
  output logic [CNT_W-1:0]  sym_count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned SPW = WORD_W / SYM_W;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCW = $clog2(DEPTH + 1);
  localparam int unsigned GW  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned BW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned CW1 = CNT_W + 1;

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  logic [WORD_W-1:0] mem [DEPTH];

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             loop_q, loop_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             stop_q, stop_d;

  logic             idle_like, full, len_bad, is_last;
  logic [CW1-1:0]   cap;
  logic             load_we;
  logic [AW-1:0]    load_addr;
  logic [AW-1:0]    word_sel;
  logic [BW-1:0]    bit_pos;
  logic [WORD_W-1:0] rd_word;

  assign idle_like  = (state_q != StStream);
  assign full       = (wcnt_q == WCW'(DEPTH));
  assign cap        = CW1'(wcnt_q) * CW1'(SPW);
  assign len_bad    = (start_len == '0) || ({1'b0, start_len} > cap);
  assign is_last    = (idx_q == len_q - 1'b1);
  assign load_ready = idle_like && !full && !start;

  // Symbol idx lives in word idx/SPW at bit offset SYM_W*(idx%SPW).
  assign word_sel = AW'(idx_q / CNT_W'(SPW));
  assign bit_pos  = BW'((idx_q % CNT_W'(SPW)) * CNT_W'(SYM_W));
  assign rd_word  = mem[word_sel];
  assign sym_data = rd_word[bit_pos +: SYM_W];

  assign sym_valid = valid_q;
  assign sym_last  = valid_q && is_last;
  assign sym_count = cnt_q;
  assign busy      = (state_q == StStream);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    loop_d    = loop_q;
    valid_d   = valid_q;
    done_d    = done_q;
    err_d     = err_q;
    stop_d    = stop_q;
    load_we   = 1'b0;
    load_addr = AW'(wcnt_q);

    unique case (state_q)
      StIdle, StDone: begin
        if (clear) begin
          // A word offered alongside clear lands at slot 0 of the emptied buffer.
          state_d = StIdle;
          wcnt_d  = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          if (load_valid && load_ready) begin
            load_we   = 1'b1;
            load_addr = '0;
            wcnt_d    = WCW'(1);
          end
        end else if (start) begin
          if (len_bad) begin
            err_d = 1'b1;
          end else begin
            len_d   = start_len;
            loop_d  = loop_en;
            idx_d   = '0;
            cnt_d   = '0;
            gap_d   = '0;
            done_d  = 1'b0;
            stop_d  = 1'b0;
            valid_d = 1'b1;
            state_d = StStream;
          end
        end else if (load_valid) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            load_we = 1'b1;
            wcnt_d  = wcnt_q + WCW'(1);
            done_d  = 1'b0;
          end
        end
      end

      StStream: begin
        if (valid_q) begin
          // A pending symbol is never withdrawn; remember stop until it transfers.
          if (stop) stop_d = 1'b1;
          if (sym_ready) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            if ((is_last && !loop_q) || stop || stop_q) begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              stop_d  = 1'b0;
              state_d = StDone;
            end else begin
              idx_d   = is_last ? '0 : idx_q + 1'b1;
              valid_d = (HOLD == 1);
              gap_d   = GW'(HOLD - 1);
            end
          end
        end else begin
          if (stop) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else if (gap_q <= GW'(1)) begin
            valid_d = 1'b1;
            gap_d   = '0;
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      loop_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      loop_q  <= loop_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      stop_q  <= stop_d;
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge CLK) begin
    if (load_we) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_symbol_stream_feeder.sv
module tb_symbol_stream_feeder;

  localparam int unsigned SYM_W  = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SPW    = WORD_W / SYM_W;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  // Instance a: HOLD=1
  logic              a_load_valid, a_load_ready, a_clear, a_start, a_loop_en, a_stop;
  logic [WORD_W-1:0] a_load_data;
  logic [CNT_W-1:0]  a_start_len, a_sym_count;
  logic              a_sym_valid, a_sym_last, a_sym_ready, a_busy, a_done, a_err;
  logic [SYM_W-1:0]  a_sym_data;

  // Instance b: HOLD=2
  logic              b_load_valid, b_load_ready, b_clear, b_start, b_loop_en, b_stop;
  logic [WORD_W-1:0] b_load_data;
  logic [CNT_W-1:0]  b_start_len, b_sym_count;
  logic              b_sym_valid, b_sym_last, b_sym_ready, b_busy, b_done, b_err;
  logic [SYM_W-1:0]  b_sym_data;

  symbol_stream_feeder #(
    .SYM_W(SYM_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .HOLD(1), .CNT_W(CNT_W)
  ) u_dut_a (
    .CLK(CLK), .RST(RST),
    .load_valid(a_load_valid), .load_data(a_load_data), .load_ready(a_load_ready),
    .clear(a_clear), .start(a_start), .start_len(a_start_len), .loop_en(a_loop_en),
    .stop(a_stop), .sym_valid(a_sym_valid), .sym_data(a_sym_data), .sym_last(a_sym_last),
    .sym_ready(a_sym_ready), .sym_count(a_sym_count), .busy(a_busy), .done(a_done),
    .err(a_err)
  );

  symbol_stream_feeder #(
    .SYM_W(SYM_W), .WORD_W(WORD_W), .DEPTH(DEPTH), .HOLD(2), .CNT_W(CNT_W)
  ) u_dut_b (
    .CLK(CLK), .RST(RST),
    .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
    .clear(b_clear), .start(b_start), .start_len(b_start_len), .loop_en(b_loop_en),
    .stop(b_stop), .sym_valid(b_sym_valid), .sym_data(b_sym_data), .sym_last(b_sym_last),
    .sym_ready(b_sym_ready), .sym_count(b_sym_count), .busy(b_busy), .done(b_done),
    .err(b_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int ridx;
    RST = 1'b1;
    a_load_valid = 0; a_load_data = '0; a_clear = 0; a_start = 0; a_start_len = '0;
    a_loop_en = 0; a_stop = 0; a_sym_ready = 0;
    b_load_valid = 0; b_load_data = '0; b_clear = 0; b_start = 0; b_start_len = '0;
    b_loop_en = 0; b_stop = 0; b_sym_ready = 0;
    step(2);

    // Reset state
    check("rst_valid", 32'(a_sym_valid), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_last", 32'(a_sym_last), 32'd0);
    check("rst_count", 32'(a_sym_count), 32'd0);
    check("rst_load_ready", 32'(a_load_ready), 32'd1);
    RST = 1'b0;
    step();

    // HOLD=2: 0xE4E4E4E4 -> 0,1,2,3 x4, valid every other cycle
    b_load_valid = 1; b_load_data = 32'hE4E4_E4E4;
    step();
    b_load_valid = 0;
    b_start = 1; b_start_len = 16; b_sym_ready = 1;
    step();
    b_start = 0;
    for (int c = 0; c < 32; c++) begin
      check("h2_valid", 32'(b_sym_valid), 32'((c % 2) == 0));
      if (c % 2 == 0) begin
        check("h2_data", 32'(b_sym_data), 32'((c / 2) % 4));
        check("h2_last", 32'(b_sym_last), 32'(c == 30));
      end
      step();
      if (c == 30) check("h2_done", 32'(b_done), 32'd1);
    end
    check("h2_count", 32'(b_sym_count), 32'd16);

    // HOLD=1 one-shot, 16 symbols back-to-back
    a_load_valid = 1; a_load_data = 32'hE4E4_E4E4;
    step();
    a_load_valid = 0;
    a_start = 1; a_start_len = 16; a_loop_en = 0; a_sym_ready = 1;
    step();
    a_start = 0;
    for (int i = 0; i < 16; i++) begin
      check("h1_valid", 32'(a_sym_valid), 32'd1);
      check("h1_data", 32'(a_sym_data), 32'(i % 4));
      check("h1_last", 32'(a_sym_last), 32'(i == 15));
      step();
    end
    check("h1_done", 32'(a_done), 32'd1);
    check("h1_valid_off", 32'(a_sym_valid), 32'd0);
    check("h1_busy_off", 32'(a_busy), 32'd0);
    check("h1_count", 32'(a_sym_count), 32'd16);

    // Backpressure: ready low for 5 cycles after 5 transfers
    a_start = 1; a_start_len = 16;
    step();
    a_start = 0;
    check("bp_done_clr", 32'(a_done), 32'd0);
    ridx = 0;
    for (int cyc = 0; cyc < 30 && ridx < 16; cyc++) begin
      a_sym_ready = !(cyc >= 5 && cyc < 10);
      check("bp_valid", 32'(a_sym_valid), 32'd1);
      check("bp_data", 32'(a_sym_data), 32'(ridx % 4));
      check("bp_last", 32'(a_sym_last), 32'(ridx == 15));
      check("bp_count", 32'(a_sym_count), 32'(ridx));
      step();
      if (a_sym_ready) ridx++;
    end
    check("bp_total", 32'(ridx), 32'd16);
    check("bp_count_end", 32'(a_sym_count), 32'd16);
    check("bp_done", 32'(a_done), 32'd1);

    // Loop replay of 1,2,3 then stop
    a_clear = 1;
    step();
    a_clear = 0;
    a_load_valid = 1; a_load_data = 32'h0000_0039;
    step();
    a_load_valid = 0;
    a_start = 1; a_start_len = 3; a_loop_en = 1; a_sym_ready = 1;
    step();
    a_start = 0;
    for (int i = 0; i < 7; i++) begin
      check("lp_data", 32'(a_sym_data), 32'((i % 3) + 1));
      check("lp_last", 32'(a_sym_last), 32'((i % 3) == 2));
      step();
    end
    a_stop = 1; a_sym_ready = 0;
    step();
    a_stop = 0;
    check("lp_stop_valid", 32'(a_sym_valid), 32'd1);
    check("lp_stop_busy", 32'(a_busy), 32'd1);
    check("lp_stop_data", 32'(a_sym_data), 32'd2);
    a_sym_ready = 1;
    step();
    check("lp_done", 32'(a_done), 32'd1);
    check("lp_busy", 32'(a_busy), 32'd0);
    check("lp_valid", 32'(a_sym_valid), 32'd0);
    check("lp_count", 32'(a_sym_count), 32'd8);

    // Fill, overflow, oversize start
    a_clear = 1;
    step();
    a_clear = 0;
    check("fl_err_clr", 32'(a_err), 32'd0);
    check("fl_done_clr", 32'(a_done), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      a_load_valid = 1; a_load_data = 32'(i + 1);
      check("fl_ready", 32'(a_load_ready), 32'd1);
      step();
    end
    check("fl_full_ready", 32'(a_load_ready), 32'd0);
    check("fl_err_pre", 32'(a_err), 32'd0);
    a_load_data = 32'hFFFF_FFFF;
    step();
    a_load_valid = 0;
    check("fl_err", 32'(a_err), 32'd1);
    a_start = 1; a_start_len = 16'(DEPTH * SPW + 1); a_loop_en = 0;
    step();
    a_start = 0;
    check("fl_big_busy", 32'(a_busy), 32'd0);
    check("fl_big_err", 32'(a_err), 32'd1);
    a_start = 1; a_start_len = 16'(DEPTH * SPW);
    step();
    a_start = 0;
    check("fl_max_busy", 32'(a_busy), 32'd1);
    check("fl_max_data", 32'(a_sym_data), 32'd1);
    step(SPW + 2);
    // Word 0 symbol 0 was followed by zeros; word 1 (=2) presents symbol 2 at index SPW.
    check("fl_w1_data", 32'(a_sym_data), 32'd0);

    // Reset mid-stream
    RST = 1;
    step();
    RST = 0;
    check("rs_valid", 32'(a_sym_valid), 32'd0);
    check("rs_busy", 32'(a_busy), 32'd0);
    check("rs_done", 32'(a_done), 32'd0);
    check("rs_err", 32'(a_err), 32'd0);
    check("rs_load_ready", 32'(a_load_ready), 32'd1);
    a_start = 1; a_start_len = 1;
    step();
    a_start = 0;
    check("rs_wcnt0_busy", 32'(a_busy), 32'd0);
    check("rs_wcnt0_err", 32'(a_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
